// File: rtl/inst_enc_loader_pkg.sv
// RV32I encoding constants, format/state enums and the field-bundle struct
// shared by the instruction encoder/loader.
package rv_isa_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  } enc_fmt_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  // Shift-immediates share the OP-IMM opcode; funct3 tells them apart.
  function automatic enc_fmt_e fmt_of(input logic [6:0] op, input logic [2:0] f3);
    enc_fmt_e f;
    case (op)
      OP_R:             f = FMT_R;
      OP_I:             f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_ISH : FMT_I;
      OP_L, OP_JALR:    f = FMT_I;
      OP_S:             f = FMT_S;
      OP_B:             f = FMT_B;
      OP_LUI, OP_AUIPC: f = FMT_U;
      OP_JAL:           f = FMT_J;
      default:          f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_enc_loader_if.sv
// Field-bundle input handshake and imem write port of the instruction loader.
interface inst_enc_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/inst_enc_loader_fifo.sv
// Synchronous encoded-word FIFO; head word is presented combinationally on o_dout.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW:0]   o_occ
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_occ;
  logic          w_push, w_pop;

  assign o_full  = (r_occ == (PW+1)'(DEPTH));
  assign o_empty = (r_occ == '0);
  assign o_occ   = r_occ;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/inst_enc_loader.sv
// RV32I instruction encoder/loader: encodes field bundles and streams them to imem.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_enc_loader
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               finish,
  input  logic [ADDR_W-1:0]  base_addr,
  inst_enc_loader_if.slave   bus,
  output logic [ADDR_W-1:0]  count,
  output logic               busy,
  output logic               done,
  output logic               full,
  output logic               err_unknown,
  output logic               err_range
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] CAP = ADDR_W'(1) << (ADDR_W-2);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr, r_count, r_slots;
  logic              r_full, r_err_unknown, r_err_range;

  enc_req_t          w_req;
  enc_fmt_e          w_fmt;
  logic [31:0]       w_word, w_dout;
  logic [ADDR_W-1:0] w_base;
  logic              w_accept, w_pop, w_range;
  logic              w_fifo_full, w_fifo_empty;
  logic [OW-1:0]     w_occ;

  function automatic logic [31:0] encode(input enc_req_t r, input enc_fmt_e f);
    logic [31:0] w;
    case (f)
      FMT_R:   w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
      FMT_I:   w = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
      FMT_ISH: w = {r.funct7, r.imm[4:0], r.rs1, r.funct3, r.rd, r.opcode};
      FMT_S:   w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
      FMT_B:   w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3, r.imm[4:1], r.imm[11], r.opcode};
      FMT_U:   w = {r.imm[31:12], r.rd, r.opcode};
      FMT_J:   w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
      default: w = NOP_WORD;
    endcase
    return w;
  endfunction

`ifdef INST_ENC_RANGE_CHECK_EN
  function automatic logic range_bad(input enc_req_t r, input enc_fmt_e f);
    logic signed [31:0] s;
    logic b;
    s = $signed(r.imm);
    case (f)
      FMT_I, FMT_S: b = (s < -2048) || (s > 2047);
      FMT_B:        b = (s < -4096) || (s > 4094) || r.imm[0];
      FMT_J:        b = (s < -1048576) || (s > 1048574) || r.imm[0];
      FMT_ISH:      b = (r.imm > 32'd31);
      FMT_U:        b = (r.imm[11:0] != 12'd0);
      default:      b = 1'b0;
    endcase
    return b;
  endfunction
  assign w_range = range_bad(w_req, w_fmt);
`else
  assign w_range = 1'b0;
`endif

  assign w_req = '{opcode: bus.in_opcode, funct3: bus.in_funct3, funct7: bus.in_funct7,
                   rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};
  assign w_fmt  = fmt_of(bus.in_opcode, bus.in_funct3);
  assign w_word = encode(w_req, w_fmt);
  assign w_base = base_addr & ~ADDR_W'(3);

  // Slots counts words still placeable from the base up to the top of imem,
  // so the address can never wrap.
  assign bus.in_ready = (r_state == ST_RUN) && !w_fifo_full && (r_slots != '0);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_pop        = !w_fifo_empty && bus.wr_ready;
  assign bus.wr_valid = !w_fifo_empty;
  assign bus.wr_data  = w_fifo_empty ? 32'd0 : w_dout;
  assign bus.wr_addr  = r_addr;

  assign count       = r_count;
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done        = (r_state == ST_DONE);
  assign full        = r_full;
  assign err_unknown = r_err_unknown;
  assign err_range   = r_err_range;

  enc_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   (w_word),
    .o_dout  (w_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_occ   (w_occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_count       <= '0;
      r_slots       <= '0;
      r_full        <= 1'b0;
      r_err_unknown <= 1'b0;
      r_err_range   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE:
          if (start) begin
            r_state       <= ST_RUN;
            r_addr        <= w_base;
            r_count       <= '0;
            r_slots       <= CAP - (w_base >> 2);
            r_full        <= 1'b0;
            r_err_unknown <= 1'b0;
            r_err_range   <= 1'b0;
          end
        ST_RUN:
          if (finish || r_slots == '0) r_state <= ST_DRAIN;
        ST_DRAIN:
          if (w_occ == '0 && !bus.wr_valid) r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
      // Accepts only happen in RUN and pops only with a non-empty FIFO,
      // so neither collides with the session-start initialisation above.
      if (w_accept) begin
        r_slots <= r_slots - 1'b1;
        if (r_slots == ADDR_W'(1)) r_full <= 1'b1;
        if (w_fmt == FMT_BAD) r_err_unknown <= 1'b1;
        if (w_range) r_err_range <= 1'b1;
      end
      if (w_pop) begin
        r_addr  <= r_addr + ADDR_W'(4);
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule
